imm_ext_pipe: RTL

Parametrised, pipelined successor to the combinational immediate extender. Accepts instruction bits [31:7] plus an immediate-type select over a valid/ready handshake. Produces the XLEN-wide extended immediate one cycle later through a 2-entry skid buffer, so the decode stage can stall without a combinational ready path. Adds RV64 support, CSR zimm, shift-amount types, an illegal-select flag, a sideband tag and a flush input.

---
 rtl/imm_ext_pipe_pkg.sv | 24 ++
 rtl/imm_ext_pipe_if.sv | 30 +++
 rtl/imm_ext_pipe_core.sv | 59 +++++
 rtl/imm_ext_pipe.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/imm_ext_pipe_pkg.sv
// Shared types for the immediate-extension pipeline: the immediate-type
// select encoding and the skid-buffer occupancy states.
package riscv_pkg;

    localparam int INSTR_W = 25;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_J     = 3'd3,
        IMM_U     = 3'd4,
        IMM_Z     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_BAD   = 3'd7
    } imm_src_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bundle between decode and the immediate-extension pipeline.
// The master side is the producer of input beats and consumer of output beats.
interface imm_ext_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    import riscv_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr;
    logic [2:0]           in_imm_src;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_imm;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_illegal;

    modport master (
        output in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );

endinterface

// File: rtl/imm_ext_pipe_core.sv
// Combinational immediate extender. instr holds instruction bits [31:7],
// so instruction bit n lives at instr[n-7].
module imm_ext_core
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_src_e           imm_src,
    output logic [XLEN-1:0]    imm,
    output logic               illegal
);

    logic [11:0] i_imm_s;
    logic [11:0] s_imm_s;
    logic [12:0] b_imm_s;
    logic [20:0] j_imm_s;
    logic [31:0] u_imm_s;
    logic [4:0]  z_imm_s;
    logic [5:0]  shamt_s;

    assign i_imm_s = instr[24:13];
    assign s_imm_s = {instr[24:18], instr[4:0]};
    assign b_imm_s = {instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
    assign j_imm_s = {instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
    assign u_imm_s = {instr[24:5], 12'h000};
    assign z_imm_s = instr[12:8];
    assign shamt_s = instr[18:13];

    // Select and extend the immediate field; signed casts give sign extension.
    always_comb begin
        imm     = {XLEN{1'b0}};
        illegal = 1'b0;
        case (imm_src)
            IMM_I: imm = XLEN'($signed(i_imm_s));
            IMM_S: imm = XLEN'($signed(s_imm_s));
            IMM_B: imm = XLEN'($signed(b_imm_s));
            IMM_J: imm = XLEN'($signed(j_imm_s));
            IMM_U: imm = XLEN'($signed(u_imm_s));
            IMM_Z: imm = XLEN'(z_imm_s);
            IMM_SHAMT: begin
                if (XLEN == 64) begin
                    imm = XLEN'(shamt_s);
                end else begin
                    imm = XLEN'(shamt_s[4:0]);
                end
            end
            IMM_BAD: begin
                imm     = {XLEN{1'b0}};
                illegal = 1'b1;
            end
            default: begin
                imm     = {XLEN{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer. M drives the
// outputs, K catches the beat accepted while M is stalled. in_ready and
// out_valid are registers, so no combinational path runs from out_ready.
module imm_ext_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    imm_ext_pipe_if.slave  bus
);

    logic [XLEN-1:0]  ext_imm_s;
    logic             ext_ill_s;

    skid_state_e      state_r;
    skid_state_e      state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [XLEN-1:0]  m_imm_r;
    logic [TAG_W-1:0] m_tag_r;
    logic             m_ill_r;
    logic [XLEN-1:0]  k_imm_r;
    logic [TAG_W-1:0] k_tag_r;
    logic             k_ill_r;

    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             load_m_in_s;
    logic             load_m_k_s;
    logic             load_k_s;

    imm_ext_core #(.XLEN(XLEN)) u_core (
        .instr   (bus.in_instr),
        .imm_src (imm_src_e'(bus.in_imm_src)),
        .imm     (ext_imm_s),
        .illegal (ext_ill_s)
    );

    assign in_xfer_s  = bus.in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && bus.out_ready;

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_imm     = m_imm_r;
    assign bus.out_tag     = m_tag_r;
    assign bus.out_illegal = m_ill_r;

    // Next occupancy state and which storage register loads this cycle.
    always_comb begin
        state_nxt_s = state_r;
        load_m_in_s = 1'b0;
        load_m_k_s  = 1'b0;
        load_k_s    = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ONE;
                        load_m_in_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_nxt_s = ONE;
                        load_m_in_s = 1'b1;
                    end else if (in_xfer_s) begin
                        state_nxt_s = FULL;
                        load_k_s    = 1'b1;
                    end else if (out_xfer_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    if (out_xfer_s) begin
                        state_nxt_s = ONE;
                        load_m_k_s  = 1'b1;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state plus the registered handshake flags derived from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != FULL);
            out_valid_r <= (state_nxt_s != EMPTY);
        end
    end

    // Main and skid data registers; flush leaves their stale contents in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_imm_r <= {XLEN{1'b0}};
            m_tag_r <= {TAG_W{1'b0}};
            m_ill_r <= 1'b0;
            k_imm_r <= {XLEN{1'b0}};
            k_tag_r <= {TAG_W{1'b0}};
            k_ill_r <= 1'b0;
        end else begin
            if (load_m_in_s) begin
                m_imm_r <= ext_imm_s;
                m_tag_r <= bus.in_tag;
                m_ill_r <= ext_ill_s;
            end else if (load_m_k_s) begin
                m_imm_r <= k_imm_r;
                m_tag_r <= k_tag_r;
                m_ill_r <= k_ill_r;
            end else begin
                m_imm_r <= m_imm_r;
                m_tag_r <= m_tag_r;
                m_ill_r <= m_ill_r;
            end
            if (load_k_s) begin
                k_imm_r <= ext_imm_s;
                k_tag_r <= bus.in_tag;
                k_ill_r <= ext_ill_s;
            end else begin
                k_imm_r <= k_imm_r;
                k_tag_r <= k_tag_r;
                k_ill_r <= k_ill_r;
            end
        end
    end

endmodule
